// File: rtl/mmu_trans_client_pkg.sv
// mmu_trans_client_pkg: shared MMU client types, LoongArch ecodes and flag-to-ecode encoder
package mmu_trans_client_pkg;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  typedef enum logic [1:0] {MMU_FETCH = 2'd0, MMU_LOAD = 2'd1, MMU_STORE = 2'd2} mmu_mem_type_e;
  typedef struct packed {
    logic [31:0] paddr;
    logic        uncache;
    logic        excp;
    logic [5:0]  ecode;
    logic [31:0] badv;
  } mmu_trans_result_t;
  // returns {excp, ecode}; earlier flags win
  function automatic logic [6:0] encode_excp(input logic tlbr, pif, pil, pis, ppi, pme);
    return tlbr ? {1'b1, ECODE_TLBR} :
           pif  ? {1'b1, ECODE_PIF}  :
           pil  ? {1'b1, ECODE_PIL}  :
           pis  ? {1'b1, ECODE_PIS}  :
           ppi  ? {1'b1, ECODE_PPI}  :
           pme  ? {1'b1, ECODE_PME}  : 7'd0;
  endfunction
endpackage

// File: rtl/mmu_trans_client_trans_result_fifo.sv
// trans_result_fifo: synchronous FIFO of translation results with flush; head reads as zero when empty
module trans_result_fifo
  import mmu_trans_client_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = mmu_trans_result_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wr, r_rd;
  logic [AW:0]    r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wr <= r_wr + 1'b1;
      if (pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr] <= din;
  end
  assign count = r_cnt;
  assign full  = r_cnt == (AW+1)'(DEPTH);
  assign empty = r_cnt == '0;
  assign dout  = empty ? '0 : r_mem[r_rd];
  // credit accounting upstream must make this impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));
endmodule

// File: rtl/mmu_trans_client.sv
// mmu_trans_client: MMU translation initiator with credit-gated issue and result FIFO.
// MMU_CLIENT_PERF_EN adds saturating request / tlbr-refill counters.
module mmu_trans_client
  import mmu_trans_client_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2,
  parameter int VALEN       = 32,
  parameter int PALEN       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [VALEN-1:0] in_vaddr_i,
  input  logic [1:0]       in_mem_type_i,
  input  logic             in_cacop_direct_i,
  output logic             req_valid_o,
  output logic [VALEN-1:0] req_vaddr_o,
  output logic [1:0]       req_mem_type_o,
  output logic             req_cacop_direct_o,
  input  logic             rsp_ready_i,
  input  logic [PALEN-1:0] rsp_paddr_i,
  input  logic             rsp_uncache_i,
  input  logic             rsp_tlbr_i,
  input  logic             rsp_pif_i,
  input  logic             rsp_pil_i,
  input  logic             rsp_pis_i,
  input  logic             rsp_ppi_i,
  input  logic             rsp_pme_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [PALEN-1:0] out_paddr_o,
  output logic             out_uncache_o,
  output logic             out_excp_o,
  output logic [5:0]       out_ecode_o,
  output logic [VALEN-1:0] out_badv_o
`ifdef MMU_CLIENT_PERF_EN
  ,
  output logic [31:0]      perf_req_cnt_o,
  output logic [31:0]      perf_tlbr_cnt_o
`endif
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 2;
  typedef struct packed {
    logic [PALEN-1:0] paddr;
    logic             uncache;
    logic             excp;
    logic [5:0]       ecode;
    logic [VALEN-1:0] badv;
  } result_t;
  result_t          w_push_data, w_head;
  logic [CW-2:0]    w_count;
  logic             w_full, w_empty, w_credit_ok, w_accept, w_push;
  logic [6:0]       w_excp;
  logic             r_pend, r_pend_kill;
  logic [VALEN-1:0] r_vaddr;
  // a credit covers both queued results and the one still in the MMU
  assign w_credit_ok        = ({1'b0, w_count} + CW'(r_pend)) < CW'(QUEUE_DEPTH);
  assign in_ready_o         = rsp_ready_i && w_credit_ok && !flush_i;
  assign req_valid_o        = in_valid_i && w_credit_ok && !flush_i;
  assign req_vaddr_o        = in_vaddr_i;
  assign req_mem_type_o     = in_mem_type_i;
  assign req_cacop_direct_o = in_cacop_direct_i;
  assign w_accept           = in_valid_i && in_ready_o;
  assign w_push             = r_pend && !r_pend_kill && !flush_i;
  assign w_excp             = encode_excp(rsp_tlbr_i, rsp_pif_i, rsp_pil_i, rsp_pis_i, rsp_ppi_i, rsp_pme_i);
  assign w_push_data        = '{paddr: rsp_paddr_i, uncache: rsp_uncache_i, excp: w_excp[6],
                                ecode: w_excp[5:0], badv: r_vaddr};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_pend_kill <= 1'b0;
      r_vaddr     <= '0;
    end else begin
      r_pend      <= w_accept;
      r_pend_kill <= flush_i && (r_pend || in_valid_i);
      if (w_accept) r_vaddr <= in_vaddr_i;
    end
  end
  trans_result_fifo #(.DEPTH(QUEUE_DEPTH), .T(result_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_i),
    .push  (w_push),
    .pop   (out_valid_o && out_ready_i),
    .din   (w_push_data),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );
  assign out_valid_o   = !w_empty;
  assign out_paddr_o   = w_head.paddr;
  assign out_uncache_o = w_head.uncache;
  assign out_excp_o    = w_head.excp;
  assign out_ecode_o   = w_head.ecode;
  assign out_badv_o    = w_head.badv;
`ifdef MMU_CLIENT_PERF_EN
  logic [31:0] r_req_cnt, r_tlbr_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_cnt  <= '0;
      r_tlbr_cnt <= '0;
    end else begin
      if (w_accept && !(&r_req_cnt)) r_req_cnt <= r_req_cnt + 1'b1;
      if (w_push && rsp_tlbr_i && !(&r_tlbr_cnt)) r_tlbr_cnt <= r_tlbr_cnt + 1'b1;
    end
  end
  assign perf_req_cnt_o  = r_req_cnt;
  assign perf_tlbr_cnt_o = r_tlbr_cnt;
`endif
endmodule

// File: tb/tb_mmu_trans_client.sv
// tb_mmu_trans_client: scoreboard bench for mmu_trans_client (perf counters checked when MMU_CLIENT_PERF_EN is defined)
module tb_mmu_trans_client;
  import mmu_trans_client_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0;
  logic        in_valid_i = 1'b0, in_ready_o, in_cacop_direct_i = 1'b0;
  logic [31:0] in_vaddr_i = '0, req_vaddr_o, rsp_paddr_i = '0, out_paddr_o, out_badv_o;
  logic [1:0]  in_mem_type_i = 2'd0, req_mem_type_o;
  logic        req_valid_o, req_cacop_direct_o, rsp_ready_i = 1'b1, rsp_uncache_i = 1'b0;
  logic        rsp_tlbr_i = 0, rsp_pif_i = 0, rsp_pil_i = 0, rsp_pis_i = 0, rsp_ppi_i = 0, rsp_pme_i = 0;
  logic        out_valid_o, out_ready_i = 1'b1, out_uncache_o, out_excp_o;
  logic [5:0]  out_ecode_o;
`ifdef MMU_CLIENT_PERF_EN
  logic [31:0] perf_req_cnt_o, perf_tlbr_cnt_o;
`endif
  typedef struct packed {
    logic [31:0] paddr;
    logic        uncache;
    logic        excp;
    logic [5:0]  ecode;
    logic [31:0] badv;
  } exp_t;
  exp_t sb[$];
  exp_t e_head;
  int   n_chk = 0, n_pass = 0, n_acc = 0, n_tlbr = 0, a0 = 0;
  logic [5:0] fl_t [7] = '{6'b101000, 6'b000011, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001};
  logic [5:0] ec_t [7] = '{6'h3F, 6'h07, 6'h03, 6'h01, 6'h02, 6'h07, 6'h04};

  mmu_trans_client dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_vaddr_i(in_vaddr_i),
    .in_mem_type_i(in_mem_type_i), .in_cacop_direct_i(in_cacop_direct_i),
    .req_valid_o(req_valid_o), .req_vaddr_o(req_vaddr_o), .req_mem_type_o(req_mem_type_o),
    .req_cacop_direct_o(req_cacop_direct_o), .rsp_ready_i(rsp_ready_i), .rsp_paddr_i(rsp_paddr_i),
    .rsp_uncache_i(rsp_uncache_i), .rsp_tlbr_i(rsp_tlbr_i), .rsp_pif_i(rsp_pif_i),
    .rsp_pil_i(rsp_pil_i), .rsp_pis_i(rsp_pis_i), .rsp_ppi_i(rsp_ppi_i), .rsp_pme_i(rsp_pme_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_paddr_o(out_paddr_o),
    .out_uncache_o(out_uncache_o), .out_excp_o(out_excp_o), .out_ecode_o(out_ecode_o),
    .out_badv_o(out_badv_o)
`ifdef MMU_CLIENT_PERF_EN
    , .perf_req_cnt_o(perf_req_cnt_o), .perf_tlbr_cnt_o(perf_tlbr_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // fl = {tlbr, pif, pil, pis, ppi, pme}; keep=1 means a result is expected at the output
  task automatic issue(input logic [31:0] va, input logic [31:0] pa, input logic unc,
                       input logic [5:0] fl, input logic [5:0] ec, input bit keep, input bit last);
    bit ok = 0;
    in_valid_i = 1'b1;
    in_vaddr_i = va;
    in_mem_type_i = va[1] ? 2'd2 : 2'd1;
    in_cacop_direct_i = va[0];
    #1;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (in_ready_o) ok = 1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    if (!ok) begin
      check("accept_timeout", in_ready_o, 1);
      in_valid_i = 1'b0;
      return;
    end
    check("req_pass", {req_valid_o, req_mem_type_o, req_cacop_direct_o, req_vaddr_o},
          {1'b1, (va[1] ? 2'd2 : 2'd1), va[0], va});
    @(posedge clk);
    #1;
    n_acc++;
    rsp_paddr_i = pa;
    rsp_uncache_i = unc;
    {rsp_tlbr_i, rsp_pif_i, rsp_pil_i, rsp_pis_i, rsp_ppi_i, rsp_pme_i} = fl;
    if (keep) begin
      sb.push_back(exp_t'{pa, unc, (ec != 6'd0), ec, va});
      if (fl[5]) n_tlbr++;
    end
    @(negedge clk);
    if (last) in_valid_i = 1'b0;
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) check("sb_unexpected", out_valid_o, 0);
      else begin
        e_head = sb.pop_front();
        check("out_result", {out_paddr_o, out_uncache_o, out_excp_o, out_ecode_o, out_badv_o}, e_head);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_data", {out_paddr_o, out_uncache_o, out_excp_o, out_ecode_o, out_badv_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // single load, result visible one cycle after the response
    issue(32'h1C00_0104, 32'h0000_0104, 1'b0, 6'd0, 6'd0, 1, 1);
    #1 check("lat_early", out_valid_o, 0);
    @(negedge clk);
    #1 check("lat_valid", out_valid_o, 1);
    repeat (2) @(negedge clk);
    // exception priority table, back to back
    for (int i = 0; i < 7; i++)
      issue(32'h0040_0000 + i * 32'h1004, 32'h9000_0000 + i * 16, i[0], fl_t[i], ec_t[i], 1, i == 6);
    repeat (4) @(negedge clk);
    check("ecode_drain", sb.size(), 0);
    // async reset with two queued results
    out_ready_i = 1'b0;
    issue(32'h5000_0000, 32'h5100_0000, 1'b0, 6'd0, 6'd0, 0, 0);
    issue(32'h5000_0010, 32'h5100_0010, 1'b0, 6'd0, 6'd0, 0, 1);
    @(negedge clk);
    #1 check("rst_q_valid", out_valid_o, 1);
    rst_n = 1'b0;
    #1 check("rst_async", out_valid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_acc = 0;
    n_tlbr = 0;
    out_ready_i = 1'b1;
    // reset in the response cycle: the late response must be ignored
    issue(32'h5000_0020, 32'h5100_0020, 1'b0, 6'd0, 6'd0, 0, 1);
    rst_n = 1'b0;
    #1 check("rst_pend_valid", out_valid_o, 0);
    #1 rst_n = 1'b1;
    n_acc = 0;
    repeat (3) @(negedge clk);
    #1 check("stale_ignored", out_valid_o, 0);
    // five requests, two refills
    for (int i = 0; i < 5; i++)
      issue(32'h6000_0000 + i * 8, 32'h6100_0000 + i * 8, 1'b0, (i == 1 || i == 3) ? 6'b100000 : 6'd0,
            (i == 1 || i == 3) ? 6'h3F : 6'd0, 1, i == 4);
    repeat (3) @(negedge clk);
`ifdef MMU_CLIENT_PERF_EN
    check("perf_req5", perf_req_cnt_o, 5);
    check("perf_tlbr2", perf_tlbr_cnt_o, 2);
`endif
    // stalled consumer: only two credits
    out_ready_i = 1'b0;
    a0 = n_acc;
    fork
      for (int i = 0; i < 4; i++)
        issue(32'h1000_0000 + i * 4, 32'h2000_0000 + i * 4, i[0], 6'd0, 6'd0, 1, i == 3);
      begin
        repeat (6) @(negedge clk);
        #1;
        check("stall_ready", in_ready_o, 0);
        check("stall_acc", n_acc - a0, 2);
        check("stall_valid", out_valid_o, 1);
        out_ready_i = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    check("stall_drain", sb.size(), 0);
    // flush with one result queued
    out_ready_i = 1'b0;
    issue(32'h3000_0000, 32'h3100_0000, 1'b0, 6'd0, 6'd0, 0, 1);
    @(negedge clk);
    #1 check("fq_valid", out_valid_o, 1);
    flush_i = 1'b1;
    #1 check("fq_ready", in_ready_o, 0);
    @(negedge clk);
    flush_i = 1'b0;
    #1 check("fq_empty", out_valid_o, 0);
    out_ready_i = 1'b1;
    // flush in the response cycle (refill response must not be counted)
    issue(32'h8000_0000, 32'h0000_8000, 1'b0, 6'b100000, 6'h3F, 0, 1);
    flush_i = 1'b1;
    #1 check("flush_ready_low", in_ready_o, 0);
    @(negedge clk);
    flush_i = 1'b0;
    #1 check("flush_ready_back", in_ready_o, 1);
    check("flush_no_out", out_valid_o, 0);
    repeat (2) @(negedge clk);
    #1 check("flush_still_empty", out_valid_o, 0);
`ifdef MMU_CLIENT_PERF_EN
    check("perf_req_end", perf_req_cnt_o, n_acc);
    check("perf_tlbr_end", perf_tlbr_cnt_o, n_tlbr);
`endif
    check("sb_final", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mmu_trans_client.md
Name: mmu_trans_client

Overview:
- Initiator side of the MMU address-translation interface. Sits between a pipeline stage (fetch or LSU address-generate) and one MMU translation port.
- Accepts virtual-address requests from the stage and drives them to the MMU.
- Captures the MMU response exactly one cycle later and encodes exception flags into a LoongArch ecode.
- Buffers results in a small FIFO, so a stalled consumer never loses a translation.

Parameters:
- QUEUE_DEPTH, 2: result FIFO entries; power of two, ≥ 2.
- VALEN, 32: virtual address width.
- PALEN, 32: physical address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- flush_i  in  1  kill all queued and in-flight translations.
- in_valid_i  in  1  stage request valid.
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o.
- in_vaddr_i  in  VALEN  virtual address.
- in_mem_type_i  in  2  MMU_FETCH=0, MMU_LOAD=1, MMU_STORE=2.
- in_cacop_direct_i  in  1  cacop direct-index op; bypasses translation.
- req_valid_o  out  1  MMU request valid.
- req_vaddr_o  out  VALEN  MMU request vaddr.
- req_mem_type_o  out  2  MMU request type.
- req_cacop_direct_o  out  1  MMU cacop flag.
- rsp_ready_i  in  1  MMU can accept a request this cycle.
- rsp_paddr_i  in  PALEN  MMU physical address, valid one cycle after request.
- rsp_uncache_i  in  1  MMU uncached attribute.
- rsp_tlbr_i, rsp_pif_i, rsp_pil_i, rsp_pis_i, rsp_ppi_i, rsp_pme_i  in  1 each  MMU exception flags.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- out_paddr_o  out  PALEN  translated address.
- out_uncache_o  out  1  uncached.
- out_excp_o  out  1  translation raised an exception.
- out_ecode_o  out  6  exception code.
- out_badv_o  out  VALEN  original vaddr, for BADV.

Behaviour:
- Request path is combinational pass-through:
  - req_valid_o = in_valid_i && credit_ok && !flush_i.
  - in_ready_o = rsp_ready_i && credit_ok && !flush_i.
  - req_* fields = in_*.
- Credits:
  - credit_ok = (fifo_count + pend) < QUEUE_DEPTH.
  - pend is a 1-bit register set on each accepted request; it always self-clears the next cycle (MMU latency fixed at 1).
  - At most one request per cycle. Back-to-back issue is allowed; pend is then reasserted every cycle.
- Response capture:
  - In the cycle after an accepted request (pend=1, pend_kill=0), push one entry into the FIFO: {paddr, uncache, excp, ecode, badv}.
  - badv comes from a vaddr register latched at acceptance. rsp_* is sampled only in that cycle.
- Ecode encoding, priority high→low:
  - tlbr → 0x3F.
  - pif → 0x03.
  - pil → 0x01.
  - pis → 0x02.
  - ppi → 0x07.
  - pme → 0x04.
  - No flag set: excp=0, ecode=0.
  - tlbr together with pil yields 0x3F only.
- Output:
  - FIFO head drives out_*; out_valid_o = !empty.
  - Pop on out_valid_o && out_ready_i.
  - Push and pop in the same cycle when full is legal. Credit accounting prevents overflow, so push while full is unreachable (assertion).
- Flush:
  - FIFO is emptied at the next edge.
  - If pend=1 in the flush cycle, or an accept and flush coincide (blocked by the !flush_i gating), set pend_kill so the response next cycle is discarded.
  - pend_kill clears with pend.
  - in_ready_o=0 during the flush cycle.
- Pointers: wrap modulo QUEUE_DEPTH. count is $clog2(QUEUE_DEPTH)+1 bits.
- Reset values: pend=0, pend_kill=0, FIFO empty.
  - Outputs: out_valid_o=0, out_* data=0, req_valid_o follows combinational input gating.
  - Reset mid-transaction drops everything; a response arriving after deassertion with pend=0 is ignored.

Optional Feature:
- Macro: MMU_CLIENT_PERF_EN.
- When defined: adds outputs perf_req_cnt_o[31:0] (accepted requests) and perf_tlbr_cnt_o[31:0] (captured, non-killed tlbr responses). Both counters saturate at 0xFFFF_FFFF and reset to 0; flush does not clear them.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package MmuClientPkg (or extend MemoryManagementUnit.svh):
  - ECODE_TLBR/PIF/PIL/PIS/PPI/PME localparams.
  - MmuMemType enum.
  - MmuTransResultSt struct {paddr, uncache, excp, ecode, badv}.
- One sub-module: trans_result_fifo, a parameterised synchronous FIFO of MmuTransResultSt with push, pop, flush, count, full and empty.

Test Plan:
- Single load: vaddr=0x1C00_0104, rsp_paddr=0x0000_0104, no flags → out_valid_o at cycle+1, paddr 0x104, excp=0.
- Consumer stalled (out_ready_i=0), QUEUE_DEPTH=2, 4 back-to-back requests → in_ready_o drops after 2 accepts. After out_ready_i=1, results pop in order with no loss.
- Response flags tlbr=1 and pil=1 for vaddr 0x0040_0000 → excp=1, ecode=0x3F, badv=0x0040_0000. Flags ppi=1 and pme=1 → ecode=0x07.
- Flush asserted in the cycle after accepting vaddr 0x8000_0000 → no output appears, FIFO empty, in_ready_o=1 again on the next cycle.
- Async reset pulsed with 2 queued entries → out_valid_o=0 immediately, count=0, stale response ignored.
- With MMU_CLIENT_PERF_EN: 5 requests, 2 with tlbr → perf_req_cnt_o=5, perf_tlbr_cnt_o=2.
